// File: rtl/mips_cpu_pkg.sv
// Shared CPU types: register names, data word, and the writeback arbiter state.
package mips_cpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t ZERO = 32'h0000_0000;

  typedef enum logic [4:0] {
    REG_ZERO, REG_AT, REG_V0, REG_V1,
    REG_A0,   REG_A1, REG_A2, REG_A3,
    REG_T0,   REG_T1, REG_T2, REG_T3, REG_T4, REG_T5, REG_T6, REG_T7,
    REG_S0,   REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
    REG_T8,   REG_T9, REG_K0, REG_K1,
    REG_GP,   REG_SP, REG_FP, REG_RA
  } reg_enum;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } wb_arb_state_e;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Two-requester regfile writeback arbiter with starvation guard for the slow unit.
// Optional build macro WB_BYPASS_EN adds two read-address bypass comparators.
module rf_wb_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          cpu_clk_50M,
  input  logic          cpu_rst,
  input  logic          wb0_valid,
  output logic          wb0_ready,
  input  reg_enum       wb0_addr,
  input  word_t         wb0_data,
  input  logic          wb1_valid,
  output logic          wb1_ready,
  input  reg_enum       wb1_addr,
  input  word_t         wb1_data,
  output logic          rfwe,
  output reg_enum       rfwa,
  output word_t         rfwd,
  output logic          starve,
  output wb_arb_state_e dbg_state
`ifdef WB_BYPASS_EN
  ,
  input  reg_enum       byp_ra1,
  input  reg_enum       byp_ra2,
  output logic          byp_hit1,
  output logic          byp_hit2,
  output word_t         byp_data1,
  output word_t         byp_data2
`endif
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  wb_arb_state_e state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          rfwe_q, rfwe_d;
  reg_enum       rfwa_q, rfwa_d;
  word_t         rfwd_q, rfwd_d;
  logic          grant0, grant1;

  // Handshake: a write transfers on a rising edge where valid && ready; ready is a
  // function of the two valids, the state and reset only, and at most one is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!cpu_rst) begin
      if (state_q == PRI0) begin
        grant0 = wb0_valid;
        grant1 = wb1_valid && !wb0_valid;
      end else begin
        grant1 = wb1_valid;
        grant0 = wb0_valid && !wb1_valid;
      end
    end
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  always_comb begin
    wait_cnt_d = 4'd0;
    if (wb1_valid && !grant1) begin
      wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
    end

    state_d = state_q;
    case (state_q)
      PRI0:    if (wait_cnt_d >= MAX_WAIT_C) state_d = PRI1;
      PRI1:    if (grant1 || !wb1_valid) state_d = PRI0;
      default: state_d = PRI0;
    endcase

    // Writes to the zero register are consumed but never reach the regfile.
    rfwe_d = (grant0 && (wb0_addr != REG_ZERO)) || (grant1 && (wb1_addr != REG_ZERO));
    rfwa_d = rfwa_q;
    rfwd_d = rfwd_q;
    if (grant0) begin
      rfwa_d = wb0_addr;
      rfwd_d = wb0_data;
    end else if (grant1) begin
      rfwa_d = wb1_addr;
      rfwd_d = wb1_data;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q    <= PRI0;
      wait_cnt_q <= 4'd0;
      rfwe_q     <= 1'b0;
      rfwa_q     <= REG_ZERO;
      rfwd_q     <= ZERO;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rfwe_q     <= rfwe_d;
      rfwa_q     <= rfwa_d;
      rfwd_q     <= rfwd_d;
    end
  end

  // Outputs are forced idle while reset is held so a write accepted just before is dropped.
  assign rfwe      = rfwe_q && !cpu_rst;
  assign rfwa      = cpu_rst ? REG_ZERO : rfwa_q;
  assign rfwd      = cpu_rst ? ZERO : rfwd_q;
  assign starve    = (state_q == PRI1) && !cpu_rst;
  assign dbg_state = state_q;

`ifdef WB_BYPASS_EN
  assign byp_hit1  = rfwe && (rfwa == byp_ra1) && (byp_ra1 != REG_ZERO);
  assign byp_hit2  = rfwe && (rfwa == byp_ra2) && (byp_ra2 != REG_ZERO);
  assign byp_data1 = rfwd;
  assign byp_data2 = rfwd;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenario tasks plus a negedge scoreboard
// holding a reference arbiter model and the expected regfile writes.
module tb_rf_wb_arbiter;
  import mips_cpu_pkg::*;

  localparam int MW = 4;

  logic          cpu_clk_50M = 1'b0;
  logic          cpu_rst     = 1'b1;
  logic          wb0_valid   = 1'b0;
  logic          wb1_valid   = 1'b0;
  reg_enum       wb0_addr    = REG_ZERO;
  reg_enum       wb1_addr    = REG_ZERO;
  word_t         wb0_data    = ZERO;
  word_t         wb1_data    = ZERO;
  logic          wb0_ready, wb1_ready, rfwe, starve;
  reg_enum       rfwa;
  word_t         rfwd;
  wb_arb_state_e dbg_state;
`ifdef WB_BYPASS_EN
  reg_enum       byp_ra1 = REG_ZERO;
  reg_enum       byp_ra2 = REG_ZERO;
  logic          byp_hit1, byp_hit2;
  word_t         byp_data1, byp_data2;
`endif

  rf_wb_arbiter #(.MAX_WAIT(MW)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .wb0_valid   (wb0_valid),
    .wb0_ready   (wb0_ready),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb1_valid   (wb1_valid),
    .wb1_ready   (wb1_ready),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .rfwe        (rfwe),
    .rfwa        (rfwa),
    .rfwd        (rfwd),
    .starve      (starve),
    .dbg_state   (dbg_state)
`ifdef WB_BYPASS_EN
    ,
    .byp_ra1     (byp_ra1),
    .byp_ra2     (byp_ra2),
    .byp_hit1    (byp_hit1),
    .byp_hit2    (byp_hit2),
    .byp_data1   (byp_data1),
    .byp_data2   (byp_data2)
`endif
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  int n_cmp = 0;
  int n_err = 0;

  // {we, addr[4:0], data[31:0]} expected on the outputs one cycle after acceptance
  logic [37:0] exp_q[$];
  logic        mon_en = 1'b0;

  logic [4:0] rfwa_b, a0_b, a1_b;
  assign rfwa_b = rfwa;
  assign a0_b   = wb0_addr;
  assign a1_b   = wb1_addr;

  wb_arb_state_e m_state = PRI0;
  logic [3:0]    m_cnt   = 4'd0;

  always @(negedge cpu_clk_50M) begin
    logic [37:0] e;
    logic        g0, g1, ewe, ew;
    logic [3:0]  cn;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        ewe = e[37] && !cpu_rst;
        n_cmp++;
        if (rfwe !== ewe) begin
          n_err++;
          $display("FAIL sb_rfwe @%0t: got %b want %b", $time, rfwe, ewe);
        end
        if (ewe) begin
          n_cmp++;
          if ({rfwa_b, rfwd} !== e[36:0]) begin
            n_err++;
            $display("FAIL sb_write @%0t: got a=%0d d=%h want a=%0d d=%h",
                     $time, rfwa_b, rfwd, e[36:32], e[31:0]);
          end
        end
      end
      g0 = 1'b0;
      g1 = 1'b0;
      if (!cpu_rst) begin
        if (m_state == PRI0) begin
          g0 = wb0_valid;
          g1 = wb1_valid && !wb0_valid;
        end else begin
          g1 = wb1_valid;
          g0 = wb0_valid && !wb1_valid;
        end
      end
      n_cmp++;
      if ({wb0_ready, wb1_ready, starve} !== {g0, g1, (m_state == PRI1) && !cpu_rst}) begin
        n_err++;
        $display("FAIL sb_grant @%0t: got r0=%b r1=%b st=%b want r0=%b r1=%b st=%b",
                 $time, wb0_ready, wb1_ready, starve, g0, g1, (m_state == PRI1) && !cpu_rst);
      end
      ew = ((g0 && a0_b != 5'd0) || (g1 && a1_b != 5'd0)) && !cpu_rst;
      exp_q.push_back({ew, g0 ? a0_b : a1_b, g0 ? wb0_data : wb1_data});
      if (cpu_rst) begin
        m_state = PRI0;
        m_cnt   = 4'd0;
      end else begin
        cn = (wb1_valid && !g1) ? ((m_cnt == 4'hF) ? 4'hF : m_cnt + 4'd1) : 4'd0;
        if (m_state == PRI0) m_state = (cn >= 4'(MW)) ? PRI1 : PRI0;
        else                 m_state = PRI0;
        m_cnt = cn;
      end
    end
  end

  task automatic step();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic test_reset();
    wb0_valid = 1'b1; wb0_addr = REG_AT; wb0_data = 32'h0000_0AAA;
    wb1_valid = 1'b1; wb1_addr = REG_V0; wb1_data = 32'h0000_0BBB;
    step();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      n_cmp++;
      if ({wb0_ready, wb1_ready, rfwe, rfwa_b, rfwd} !== 40'd0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: got r0=%b r1=%b we=%b a=%0d d=%h want all zero",
                 i, wb0_ready, wb1_ready, rfwe, rfwa_b, rfwd);
      end
      step();
    end
    cpu_rst = 1'b0;
    #4;
    n_cmp++;
    if ({wb0_ready, wb1_ready, rfwe, dbg_state} !== {1'b1, 1'b0, 1'b0, PRI0}) begin
      n_err++;
      $display("FAIL reset_release: got r0=%b r1=%b we=%b st=%0d want r0=1 r1=0 we=0 st=0",
               wb0_ready, wb1_ready, rfwe, dbg_state);
    end
    step();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_priority();
    wb0_valid = 1'b1; wb0_addr = reg_enum'(5'd5); wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_addr = reg_enum'(5'd6); wb1_data = 32'h22;
    #4;
    n_cmp++;
    if ({wb0_ready, wb1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL prio_grant: got r0=%b r1=%b want r0=1 r1=0", wb0_ready, wb1_ready);
    end
    step();
    wb0_valid = 1'b0;
    #4;
    n_cmp++;
    if ({rfwe, rfwa_b, rfwd} !== {1'b1, 5'd5, 32'h11}) begin
      n_err++;
      $display("FAIL prio_write: got we=%b a=%0d d=%h want we=1 a=5 d=11", rfwe, rfwa_b, rfwd);
    end
    step();
    wb1_valid = 1'b0;
    #4;
    n_cmp++;
    if ({rfwe, rfwa_b, rfwd} !== {1'b1, 5'd6, 32'h22}) begin
      n_err++;
      $display("FAIL prio_loser: got we=%b a=%0d d=%h want we=1 a=6 d=22", rfwe, rfwa_b, rfwd);
    end
    step();
  endtask

  task automatic test_starvation();
    word_t d1;
    d1 = $urandom;
    wb1_valid = 1'b1; wb1_addr = reg_enum'(5'd12); wb1_data = d1;
    wb0_valid = 1'b1;
    for (int i = 0; i < MW; i++) begin
      wb0_addr = reg_enum'(5'($urandom_range(1, 31)));
      wb0_data = $urandom;
      #4;
      n_cmp++;
      if ({starve, wb0_ready, wb1_ready} !== 3'b010) begin
        n_err++;
        $display("FAIL starve_refuse%0d: got st=%b r0=%b r1=%b want st=0 r0=1 r1=0",
                 i, starve, wb0_ready, wb1_ready);
      end
      step();
    end
    #4;
    n_cmp++;
    if ({starve, wb0_ready, wb1_ready, dbg_state} !== {3'b101, PRI1}) begin
      n_err++;
      $display("FAIL starve_force: got st=%b r0=%b r1=%b want st=1 r0=0 r1=1",
               starve, wb0_ready, wb1_ready);
    end
    step();
    wb1_valid = 1'b0;
    #4;
    n_cmp++;
    if ({rfwe, rfwa_b, rfwd, starve, wb0_ready} !== {1'b1, 5'd12, d1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL starve_after: got we=%b a=%0d d=%h st=%b r0=%b want we=1 a=12 d=%h st=0 r0=1",
               rfwe, rfwa_b, rfwd, starve, wb0_ready, d1);
    end
    step();
    wb0_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_reg();
    wb0_valid = 1'b1; wb0_addr = REG_ZERO; wb0_data = 32'hDEAD;
    #4;
    n_cmp++;
    if (wb0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL zero_ready: got %b want 1", wb0_ready);
    end
    step();
    wb0_valid = 1'b0;
    #4;
    n_cmp++;
    if (rfwe !== 1'b0) begin
      n_err++;
      $display("FAIL zero_we: got %b want 0", rfwe);
    end
    step();
  endtask

  task automatic test_same_addr();
    word_t da, db;
    da = $urandom; db = ~da;
    wb0_valid = 1'b1; wb0_addr = reg_enum'(5'd7); wb0_data = da;
    wb1_valid = 1'b1; wb1_addr = reg_enum'(5'd7); wb1_data = db;
    step();
    wb0_valid = 1'b0;
    #4;
    n_cmp++;
    if ({rfwe, rfwa_b, rfwd} !== {1'b1, 5'd7, da}) begin
      n_err++;
      $display("FAIL same_first: got we=%b a=%0d d=%h want we=1 a=7 d=%h", rfwe, rfwa_b, rfwd, da);
    end
    step();
    wb1_valid = 1'b0;
    #4;
    n_cmp++;
    if ({rfwe, rfwa_b, rfwd} !== {1'b1, 5'd7, db}) begin
      n_err++;
      $display("FAIL same_second: got we=%b a=%0d d=%h want we=1 a=7 d=%h", rfwe, rfwa_b, rfwd, db);
    end
    step();
    #4;
    n_cmp++;
    if (rfwe !== 1'b0) begin
      n_err++;
      $display("FAIL same_idle: got we=%b want 0", rfwe);
    end
    step();
  endtask

  task automatic test_reset_mid();
    wb0_valid = 1'b1; wb0_addr = REG_A0; wb0_data = 32'hCAFE_0004;
    step();
    cpu_rst = 1'b1;
    #4;
    n_cmp++;
    if ({rfwe, wb0_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_discard: got we=%b r0=%b want we=0 r0=0", rfwe, wb0_ready);
    end
    step();
    cpu_rst   = 1'b0;
    wb0_valid = 1'b0;
    #4;
    n_cmp++;
    if ({rfwe, dbg_state} !== {1'b0, PRI0}) begin
      n_err++;
      $display("FAIL rst_resume: got we=%b st=%0d want we=0 st=0", rfwe, dbg_state);
    end
    step();
  endtask

  task automatic test_random();
    logic hold0, hold1;
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!hold0) begin
        wb0_valid = ($urandom_range(0, 3) != 0);
        wb0_addr  = reg_enum'(5'($urandom_range(0, 31)));
        wb0_data  = $urandom;
      end
      if (!hold1) begin
        wb1_valid = ($urandom_range(0, 2) != 0);
        wb1_addr  = reg_enum'(5'($urandom_range(0, 31)));
        wb1_data  = $urandom;
      end
      #4;
      hold0 = wb0_valid && !wb0_ready;
      hold1 = wb1_valid && !wb1_ready;
      step();
    end
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    step();
    step();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    byp_ra1 = reg_enum'(5'd9);
    byp_ra2 = REG_ZERO;
    wb0_valid = 1'b1; wb0_addr = reg_enum'(5'd9); wb0_data = 32'h55;
    #4;
    n_cmp++;
    if (byp_hit1 !== 1'b0) begin
      n_err++;
      $display("FAIL byp_idle: got hit1=%b want 0", byp_hit1);
    end
    step();
    wb0_valid = 1'b0;
    #4;
    n_cmp++;
    if ({byp_hit1, byp_data1, byp_hit2} !== {1'b1, 32'h55, 1'b0}) begin
      n_err++;
      $display("FAIL byp_hit: got hit1=%b d1=%h hit2=%b want hit1=1 d1=55 hit2=0",
               byp_hit1, byp_data1, byp_hit2);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_starvation();
    test_zero_reg();
    test_same_addr();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, giving the cycles req1 may be refused before it is forced priority (legal range 1..15).
REQ-002 SHALL have port cpu_clk_50M  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports wb0_valid in 1, wb0_ready out 1, wb0_addr in reg_enum, wb0_data in word_t  pipeline writeback requester.
REQ-005 SHALL have ports wb1_valid in 1, wb1_ready out 1, wb1_addr in reg_enum, wb1_data in word_t  long-latency unit (load/mul-div) requester.
REQ-006 SHALL have ports rfwe out 1, rfwa out reg_enum, rfwd out word_t  registered regfile write port.
REQ-007 SHALL have port starve out 1  high while the arbiter is in state PRI1.

Function
REQ-008 A requester's write is accepted in a cycle when its valid and ready are both high.
REQ-009 At most one of wb0_ready, wb1_ready SHALL be high in any cycle.
REQ-010 The ready signals SHALL depend on the valid inputs and the arbiter state only, never on addr or data.
REQ-011 The FSM SHALL have two states: PRI0 (reset state, wb0 wins) and PRI1 (wb1 wins).
REQ-012 In PRI0: grant wb0 if wb0_valid, else grant wb1 if wb1_valid.
REQ-013 In PRI1: grant wb1 if wb1_valid, else grant wb0 if wb0_valid.
REQ-014 4-bit wait_cnt SHALL increment, saturating at 15, each cycle wb1_valid is high and wb1 is not granted.
REQ-015 wait_cnt SHALL clear on any cycle wb1 is granted or wb1_valid is low.
REQ-016 PRI0->PRI1 when wait_cnt reaches MAX_WAIT; takes effect on the following cycle.
REQ-017 PRI1->PRI0 on the cycle after wb1 is granted, or on the cycle after wb1_valid is low in PRI1.
REQ-018 An accepted write SHALL appear on rfwe/rfwa/rfwd exactly 1 cycle after acceptance.
REQ-019 With no acceptance in a cycle, rfwe SHALL be 0 in the next cycle; rfwa and rfwd are then don't-care.
REQ-020 A write accepted with addr == REG_ZERO SHALL be consumed (ready high) but SHALL produce rfwe=0.
REQ-021 When both requesters target the same register in one cycle, only the granted write SHALL issue; the loser is retried later, never merged.
REQ-022 A refused requester's addr/data are not latched; the requester holds them stable until accepted.

Reset
REQ-023 While cpu_rst is high, state SHALL be PRI0, wait_cnt 0, rfwe 0, rfwa REG_ZERO, rfwd ZERO, wb0_ready 0, wb1_ready 0, starve 0.
REQ-024 A write accepted in the cycle before reset asserts SHALL be discarded; rfwe is 0 during reset.
REQ-025 On the first cycle after reset deasserts, arbitration SHALL resume from PRI0 with no pending write.

Configuration
REQ-026 Macro WB_BYPASS_EN SHALL add inputs byp_ra1 and byp_ra2 (reg_enum) and outputs byp_hit1, byp_hit2 (1) and byp_data1, byp_data2 (word_t).
REQ-027 With WB_BYPASS_EN: byp_hitN = rfwe && rfwa == byp_raN && byp_raN != REG_ZERO, and byp_dataN = rfwd (combinational).
REQ-028 Without WB_BYPASS_EN, these ports and their logic SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-029 reg_enum, word_t, ZERO and REG_ZERO SHALL come from mips_cpu_pkg.
REQ-030 The state enum wb_arb_state_e {PRI0, PRI1} SHALL be added to mips_cpu_pkg.
REQ-031 No sub-module is required; the bypass compare is inline logic.

Verification
REQ-032 Reset: hold cpu_rst 3 cycles with both valids high -> both readys 0 and rfwe 0 throughout; first cycle after release -> wb0_ready=1.
REQ-033 Priority: wb0 (addr 5, data 0x11) and wb1 (addr 6, data 0x22) valid together -> wb0 granted; next cycle rfwe=1, rfwa=5, rfwd=0x11.
REQ-034 Starvation: wb0 valid continuously, wb1 valid, MAX_WAIT=4 -> after 4 refusals starve=1, then wb1 granted next cycle; rfwa=wb1_addr one cycle later; then back to PRI0.
REQ-035 Zero register: wb0 writes REG_ZERO, data 0xDEAD -> wb0_ready=1; next cycle rfwe=0.
REQ-036 Same-address conflict: both requesters target addr 7 -> two writes issue on consecutive cycles, wb0 data first, wb1 data second.
REQ-037 Bypass (WB_BYPASS_EN): issued write addr 9, data 0x55 with byp_ra1=9 and byp_ra2=0 -> byp_hit1=1, byp_data1=0x55, byp_hit2=0.
